// File: rtl/uart_tx_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Round-robin arbiter/sequencer sharing one byte-wide UART
//               transmitter between NREQ requesters, with burst locking and
//               start/lock watchdogs.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
  parameter int NREQ          = 4,
  parameter int START_TIMEOUT = 16,
  parameter int LOCK_TIMEOUT  = 1024,
  localparam int IDW          = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic              tx_start,
  output logic [7:0]        tx_byte,
  input  logic              tx_busy,
  output logic [IDW-1:0]    grant_id,
  output logic              active,
  output logic              err_start,
  output logic              err_lock
);

  // One shared watchdog counter serves both timeouts; size it for the larger.
  localparam int c_cnt_max = (START_TIMEOUT > LOCK_TIMEOUT) ? START_TIMEOUT : LOCK_TIMEOUT;
  localparam int CW        = $clog2(c_cnt_max + 1);

  localparam logic [CW-1:0]  c_start_last = CW'(START_TIMEOUT - 1);
  localparam logic [CW-1:0]  c_lock_last  = CW'(LOCK_TIMEOUT - 1);
  localparam logic [IDW:0]   c_nreq       = (IDW + 1)'(NREQ);
  localparam logic [IDW-1:0] c_one        = IDW'(1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_START     = 3'd2,
    S_WAIT_BUSY = 3'd3,
    S_WAIT_DONE = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  owner_q, owner_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic            lock_q, lock_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      tx_byte_q, tx_byte_d;

  logic [NREQ-1:0]      w_rot_valid;
  logic                 w_any;
  logic [IDW-1:0]       w_offset;
  logic [IDW-1:0]       w_pick;
  logic [IDW-1:0]       w_next_ptr;
  logic [NREQ-1:0][7:0] w_data_arr;

  // Modulo-NREQ addition for requester indices (NREQ need not be a power of 2).
  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] a,
                                              input logic [IDW-1:0] b);
    logic [IDW:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= c_nreq) s = s - c_nreq;
    return s[IDW-1:0];
  endfunction

  assign w_data_arr = req_data;

  // Rotate the request vector so bit 0 is rr_ptr, then take the lowest set bit.
  always_comb begin
    w_rot_valid = NREQ'({req_valid, req_valid} >> rr_ptr_q);
    w_any       = |w_rot_valid;
    w_offset    = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (w_rot_valid[i]) w_offset = IDW'(i);
    end
  end

  assign w_pick     = wrap_add(rr_ptr_q, w_offset);
  assign w_next_ptr = wrap_add(owner_q, c_one);

  // Next-state and output decode; counter clears unless a wait is in progress.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_ptr_d  = rr_ptr_q;
    lock_d    = lock_q;
    cnt_d     = '0;
    tx_byte_d = tx_byte_q;
    req_ready = '0;
    tx_start  = 1'b0;
    err_start = 1'b0;
    err_lock  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (w_any) begin
          owner_d = w_pick;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        req_ready[owner_q] = req_valid[owner_q];
        if (req_valid[owner_q]) begin
          tx_byte_d = w_data_arr[owner_q];
          lock_d    = ~req_last[owner_q];
          state_d   = S_START;
        end else if (cnt_q == c_lock_last) begin
          // Locked owner went quiet too long: revoke and move past it.
          err_lock = 1'b1;
          lock_d   = 1'b0;
          rr_ptr_d = w_next_ptr;
          state_d  = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_START: begin
        tx_start = 1'b1;
        state_d  = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = S_WAIT_DONE;
        end else if (cnt_q == c_start_last) begin
          // Transmitter never acknowledged: the byte is dropped.
          err_start = 1'b1;
          lock_d    = 1'b0;
          rr_ptr_d  = w_next_ptr;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (!tx_busy) begin
          if (lock_q) begin
            state_d = S_ISSUE;
          end else begin
            rr_ptr_d = w_next_ptr;
            state_d  = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      owner_q   <= '0;
      rr_ptr_q  <= '0;
      lock_q    <= 1'b0;
      cnt_q     <= '0;
      tx_byte_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_ptr_q  <= rr_ptr_d;
      lock_q    <= lock_d;
      cnt_q     <= cnt_d;
      tx_byte_q <= tx_byte_d;
    end
  end

  assign tx_byte  = tx_byte_q;
  assign grant_id = owner_q;
  assign active   = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Self-checking bench: transaction-level round-robin model plus
//               directed timing checks for uart_tx_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

  localparam int NREQ          = 4;
  localparam int START_TIMEOUT = 16;
  localparam int LOCK_TIMEOUT  = 1024;
  localparam int BUSY_LEN      = 10;

  logic              clk       = 1'b0;
  logic              rst_n     = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [8*NREQ-1:0] req_data  = '0;
  logic [NREQ-1:0]   req_last  = '0;
  logic [NREQ-1:0]   req_ready;
  logic              tx_start;
  logic [7:0]        tx_byte;
  logic              tx_busy   = 1'b0;
  logic [1:0]        grant_id;
  logic              active;
  logic              err_start;
  logic              err_lock;

  int vectors     = 0;
  int miscompares = 0;

  // Requester byte queues: {last, data}, ring of 16 per requester.
  logic [8:0] rq_mem  [NREQ][16];
  int         rq_head [NREQ];
  int         rq_tail [NREQ];

  logic [NREQ-1:0] rdy_s     = '0;
  logic            tx_seen_s = 1'b0;
  bit              no_busy   = 1'b0;
  bit              chk_noerr = 1'b1;
  int              busy_cnt  = 0;
  int              m_ptr     = 0;

  logic [15:0] exp_q [$];
  logic [15:0] log_q [$];

  uart_tx_arbiter #(
    .NREQ(NREQ), .START_TIMEOUT(START_TIMEOUT), .LOCK_TIMEOUT(LOCK_TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .tx_start(tx_start), .tx_byte(tx_byte),
    .tx_busy(tx_busy), .grant_id(grant_id), .active(active),
    .err_start(err_start), .err_lock(err_lock)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input int id, input logic last, input logic [7:0] d);
    rq_mem[id][rq_tail[id] % 16] = {last, d};
    rq_tail[id]++;
  endtask

  function automatic bit queues_empty();
    for (int i = 0; i < NREQ; i++) if (rq_head[i] != rq_tail[i]) return 1'b0;
    return 1'b1;
  endfunction

  // Transaction-level model: serve whole bursts in round-robin order from the
  // pending queues; a burst ends on last=1 or when its owner runs dry (lock
  // timeout). Pointer moves past each served owner.
  task automatic run_model();
    int   cur [NREQ];
    bit   any;
    int   own;
    logic [8:0] e;
    for (int i = 0; i < NREQ; i++) cur[i] = rq_head[i];
    do begin
      any = 1'b0;
      own = 0;
      for (int k = 0; k < NREQ; k++) begin
        int id;
        id = (m_ptr + k) % NREQ;
        if (!any && cur[id] != rq_tail[id]) begin
          any = 1'b1;
          own = id;
        end
      end
      if (any) begin
        do begin
          e = rq_mem[own][cur[own] % 16];
          cur[own]++;
          exp_q.push_back({8'(own), e[7:0]});
        end while (!e[8] && cur[own] != rq_tail[own]);
        m_ptr = (own + 1) % NREQ;
      end
    end while (any);
  endtask

  function automatic logic sig_sel(input int sel);
    case (sel)
      0:       return tx_start;
      1:       return tx_busy;
      2:       return err_start;
      3:       return err_lock;
      default: return active;
    endcase
  endfunction

  task automatic wait_sig(input string name, input int sel, input logic val,
                          input int budget, output int n);
    bit hit;
    hit = 1'b0;
    n   = 0;
    while (!hit && n < budget) begin
      @(negedge clk);
      n++;
      hit = (sig_sel(sel) === val);
    end
    check({name, "_seen"}, 32'(hit), 32'd1);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    bit done;
    n    = 0;
    done = 1'b0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
      done = !active && !tx_busy && queues_empty();
    end
    check({name, "_idle"}, 32'(done), 32'd1);
    check({name, "_drained"}, exp_q.size(), 32'd0);
  endtask

  // Requester and transmitter models: update inputs just after each rising edge.
  initial begin : drv
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (!rst_n) rq_head[i] = rq_tail[i];
        else if (rdy_s[i] && rq_head[i] != rq_tail[i]) rq_head[i]++;
        if (rq_head[i] != rq_tail[i]) begin
          req_valid[i]       = 1'b1;
          req_data[8*i +: 8] = rq_mem[i][rq_head[i] % 16][7:0];
          req_last[i]        = rq_mem[i][rq_head[i] % 16][8];
        end else begin
          req_valid[i]       = 1'b0;
          req_data[8*i +: 8] = 8'h00;
          req_last[i]        = 1'b0;
        end
      end
      if (!rst_n)                     busy_cnt = 0;
      else if (tx_seen_s && !no_busy) busy_cnt = BUSY_LEN;
      else if (busy_cnt > 0)          busy_cnt--;
      tx_busy = (busy_cnt > 0);
    end
  end

  // Compare process: protocol checks every cycle, model check on every start.
  initial begin : cmp
    logic [15:0] e;
    forever begin
      @(negedge clk);
      rdy_s     = req_ready;
      tx_seen_s = tx_start;
      if (rst_n) begin
        check("ready_onehot", 32'($onehot0(req_ready)), 32'd1);
        check("ready_subset", 32'(req_ready & ~req_valid), 32'd0);
        if (chk_noerr) begin
          check("err_start_quiet", 32'(err_start), 32'd0);
          check("err_lock_quiet", 32'(err_lock), 32'd0);
        end
        if (tx_start) begin
          log_q.push_back({6'b0, grant_id, tx_byte});
          if (exp_q.size() == 0) begin
            check("start_unexpected", {16'h0, 6'b0, grant_id, tx_byte}, 32'hffff_ffff);
          end else begin
            e = exp_q.pop_front();
            check("start_owner", 32'(grant_id), 32'(e[15:8]));
            check("start_byte", 32'(tx_byte), 32'(e[7:0]));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL global_timeout: got no completion, expected finish before 400us");
    $fatal(1);
  end

  initial begin : main
    int k;
    for (int i = 0; i < NREQ; i++) begin
      rq_head[i] = 0;
      rq_tail[i] = 0;
    end
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_active", 32'(active), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    check("rst_tx_byte", 32'(tx_byte), 32'd0);
    check("rst_errs", 32'({err_start, err_lock}), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single byte from requester 2: ready at cycle 1, start at cycle 2
    push(2, 1'b1, 8'h55);
    run_model();
    @(posedge clk);
    @(negedge clk);
    check("t1_c0_ready", 32'(req_ready), 32'd0);
    check("t1_c0_active", 32'(active), 32'd0);
    @(negedge clk);
    check("t1_c1_ready", 32'(req_ready), 32'b0100);
    check("t1_c1_grant", 32'(grant_id), 32'd2);
    check("t1_c1_start", 32'(tx_start), 32'd0);
    @(negedge clk);
    check("t1_c2_start", 32'(tx_start), 32'd1);
    check("t1_c2_byte", 32'(tx_byte), 32'h55);
    wait_idle("t1", 100);

    // Pointer now at 3: requester 3 beats requester 0
    log_q.delete();
    push(0, 1'b1, 8'h01);
    push(3, 1'b1, 8'h03);
    run_model();
    wait_idle("t2", 200);
    check("t2_log0", 32'(log_q[0]), 32'h0303);
    check("t2_log1", 32'(log_q[1]), 32'h0001);

    // Locked burst from requester 1 while requester 0 waits
    log_q.delete();
    push(1, 1'b0, 8'hA1);
    push(1, 1'b0, 8'hA2);
    push(1, 1'b1, 8'hA3);
    push(0, 1'b1, 8'h10);
    run_model();
    wait_idle("t3", 300);
    check("t3_log_len", log_q.size(), 32'd4);
    check("t3_log0", 32'(log_q[0]), 32'h01A1);
    check("t3_log1", 32'(log_q[1]), 32'h01A2);
    check("t3_log2", 32'(log_q[2]), 32'h01A3);
    check("t3_log3", 32'(log_q[3]), 32'h0010);

    // Start timeout: transmitter never goes busy
    no_busy   = 1'b1;
    chk_noerr = 1'b0;
    push(1, 1'b1, 8'h77);
    run_model();
    wait_sig("t4_start", 0, 1'b1, 20, k);
    wait_sig("t4_err", 2, 1'b1, 40, k);
    check("t4_err_delay", k, START_TIMEOUT);
    check("t4_err_grant", 32'(grant_id), 32'd1);
    @(negedge clk);
    check("t4_err_pulse", 32'(err_start), 32'd0);
    check("t4_idle", 32'(active), 32'd0);
    no_busy   = 1'b0;
    chk_noerr = 1'b1;
    wait_idle("t4", 50);

    // Lock timeout: requester 2 opens a burst then goes quiet; 1 is pending
    log_q.delete();
    chk_noerr = 1'b0;
    push(2, 1'b0, 8'h21);
    push(1, 1'b1, 8'h31);
    run_model();
    wait_sig("t5_start", 0, 1'b1, 20, k);
    wait_sig("t5_busy_hi", 1, 1'b1, 20, k);
    wait_sig("t5_busy_lo", 1, 1'b0, 40, k);
    wait_sig("t5_err", 3, 1'b1, LOCK_TIMEOUT + 100, k);
    check("t5_err_delay", k, LOCK_TIMEOUT);
    check("t5_err_grant", 32'(grant_id), 32'd2);
    @(negedge clk);
    check("t5_err_pulse", 32'(err_lock), 32'd0);
    chk_noerr = 1'b1;
    wait_idle("t5", 200);
    check("t5_log0", 32'(log_q[0]), 32'h0221);
    check("t5_log1", 32'(log_q[1]), 32'h0131);

    // Reset in WAIT_BUSY during a requester-3 burst
    push(3, 1'b0, 8'h3A);
    push(3, 1'b1, 8'h3B);
    run_model();
    wait_sig("t6_start", 0, 1'b1, 20, k);
    @(negedge clk);
    check("t6_pre_active", 32'(active), 32'd1);
    rst_n = 1'b0;
    exp_q.delete();
    m_ptr = 0;
    #1;
    check("t6_active", 32'(active), 32'd0);
    check("t6_grant", 32'(grant_id), 32'd0);
    check("t6_tx_start", 32'(tx_start), 32'd0);
    check("t6_ready", 32'(req_ready), 32'd0);
    check("t6_tx_byte", 32'(tx_byte), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Contention 0,1,3 from a fresh pointer: 0,1,3,0,1,3
    log_q.delete();
    push(0, 1'b1, 8'hC0);
    push(1, 1'b1, 8'hC1);
    push(3, 1'b1, 8'hC3);
    push(0, 1'b1, 8'hD0);
    push(1, 1'b1, 8'hD1);
    push(3, 1'b1, 8'hD3);
    run_model();
    wait_idle("t7", 500);
    check("t7_log_len", log_q.size(), 32'd6);
    check("t7_log0", 32'(log_q[0]), 32'h00C0);
    check("t7_log1", 32'(log_q[1]), 32'h01C1);
    check("t7_log2", 32'(log_q[2]), 32'h03C3);
    check("t7_log3", 32'(log_q[3]), 32'h00D0);
    check("t7_log4", 32'(log_q[4]), 32'h01D1);
    check("t7_log5", 32'(log_q[5]), 32'h03D3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin arbiter and sequencer that shares one byte-wide UART transmitter between NREQ requesters. Each requester offers bytes on a valid/ready handshake and may lock the transmitter for a multi-byte burst using a last flag. The block issues single-cycle start pulses to the transmitter and tracks its busy flag, with a watchdog on both the start handshake and idle gaps within a burst. It sits between the command/report sources and the UART transmit datapath.

Parameters:
NREQ, 4, number of requesters (2..8)
START_TIMEOUT, 16, cycles allowed from tx_start until tx_busy rises
LOCK_TIMEOUT, 1024, cycles a locked owner may leave req_valid low before the lock is revoked

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NREQ  per-requester byte valid
req_data  in  8*NREQ  byte for requester i on bits [8i+7:8i]
req_last  in  NREQ  byte is the last of its burst; 1 on single-byte transfers
req_ready  out  NREQ  one-hot accept strobe, combinational from state/owner/req_valid
tx_start  out  1  one-cycle start pulse to the transmitter
tx_byte  out  8  byte to transmit, valid while tx_start=1, held until the next accept
tx_busy  in  1  transmitter busy flag
grant_id  out  clog2(NREQ)  current owner index
active  out  1  a grant is held (state != IDLE)
err_start  out  1  one-cycle pulse: tx_busy did not rise within START_TIMEOUT
err_lock  out  1  one-cycle pulse: locked owner exceeded LOCK_TIMEOUT

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; rr_ptr=0; owner=0; lock=0; counters=0. Asserting reset mid-transfer drops tx_start and req_ready immediately. The transmitter's own reset is the system's concern.
- States: IDLE, ISSUE, START, WAIT_BUSY, WAIT_DONE.
- IDLE: if any req_valid, owner <= first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... wrapping mod NREQ; go to ISSUE. If none, stay.
- ISSUE: req_ready[owner] = req_valid[owner]. All other req_ready bits are 0.
  - On transfer: tx_byte <= req_data[owner]; lock <= ~req_last[owner]; clear counter; go to START.
  - If req_valid[owner]=0 (only possible while lock=1): count cycles. At LOCK_TIMEOUT, pulse err_lock, clear lock, rr_ptr <= owner+1, go to IDLE.
- START: tx_start=1 for exactly this cycle; counter cleared; go to WAIT_BUSY.
- WAIT_BUSY: if tx_busy=1, go to WAIT_DONE. Otherwise the counter increments. When the counter reaches START_TIMEOUT, pulse err_start, clear lock, rr_ptr <= owner+1, go to IDLE (byte dropped).
- WAIT_DONE: when tx_busy=0:
  - if lock=1, go to ISSUE with the same owner;
  - else rr_ptr <= owner+1 mod NREQ and go to IDLE.
  - No timeout applies in this state.
- Latency: req_valid rising in IDLE at cycle 0 gives req_ready at cycle 1 and tx_start at cycle 2.
- Fairness: without lock, each grant covers one byte and the pointer advances past the winner. With lock, no other requester is served until a byte with req_last=1 completes or the lock times out.
- Requesters must hold req_valid, req_data and req_last stable until req_ready. A requester dropping valid before ready is a protocol violation; the block simply does not accept.
- req_valid from non-owners is ignored outside IDLE; pending requests wait.
- Simultaneous requests are resolved by rr_ptr order only. NREQ=1 degenerates to a pass-through sequencer.
- grant_id holds owner in every non-IDLE state and keeps its last value in IDLE; active = (state != IDLE).
- Counters saturate at their timeout value.

Test Plan:
- Single byte: req_valid[2]=1, data 0x55, last=1, rr_ptr=0 -> req_ready[2] at cycle 1, tx_start with tx_byte=0x55 at cycle 2; busy modeled 10 cycles; afterwards IDLE, rr_ptr=3.
- Contention: req 0,1,3 all valid with last=1, rr_ptr=0 -> grant order 0,1,3,0...; each grant carries exactly one byte; req 2 never granted.
- Locked burst: req1 sends 0xA1, 0xA2, 0xA3 (last on 0xA3) while req0 is also valid -> three consecutive tx_starts with owner 1, then req0 is granted.
- Start timeout: tx_busy held 0 after tx_start -> err_start pulses exactly 16 cycles later, state returns to IDLE, rr_ptr=owner+1.
- Lock timeout: req2 sends a byte with last=0 then drops valid -> err_lock after 1024 cycles in ISSUE; next grant goes to another pending requester.
- Reset mid-burst: rst_n low during WAIT_BUSY -> outputs 0 immediately, rr_ptr=0; after release, normal arbitration resumes from requester 0.
